apu_pulse_gen: RTL and testbench

Parametrised square-wave channel for the APU. It is the successor to the fixed NES pulse channel: timer width is configurable, the sweep negate mode is set by parameter, and a programmable 8-step duty pattern is added. The output is registered, and sweep-mute status is exported. It sits beside the triangle, noise and DMC channels, driven by the frame-counter pulses and the $4000–$4007-style register bus, and feeds the mixer.

---
 rtl/apu_pkg.sv | 39 +++
 rtl/apu_pulse_divider.sv | 38 +++
 rtl/apu_pulse_gen.sv | 209 ++++++++++++++++++++
 tb/tb_apu_pulse_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared constants and register layouts for the APU pulse channel.
package apu_pkg;

   // Register addresses on the channel's write bus
   localparam logic [2:0] ADDR_CTRL      = 3'd0;
   localparam logic [2:0] ADDR_SWEEP     = 3'd1;
   localparam logic [2:0] ADDR_TIMER_LO  = 3'd2;
   localparam logic [2:0] ADDR_TIMER_HI  = 3'd3;
   localparam logic [2:0] ADDR_CUSTOM    = 3'd4;
   localparam logic [2:0] ADDR_CUSTOM_EN = 3'd5;

   // Built-in duty patterns, indexed by the 2-bit duty field
   localparam logic [7:0] DUTY_PAT [4] = '{8'h80, 8'hC0, 8'hF0, 8'h3F};

   // Length counter load values, indexed by d[7:3] of the timer-high write
   localparam logic [7:0] LEN_TABLE [32] = '{
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   // Address 0 layout
   typedef struct packed {
      logic [1:0] duty;
      logic       halt;
      logic       const_vol;
      logic [3:0] vol;
   } ctrl_reg_t;

   // Address 1 layout
   typedef struct packed {
      logic       en;
      logic [2:0] period;
      logic       negate;
      logic [2:0] shift;
   } sweep_reg_t;

endpackage

// File: rtl/apu_pulse_divider.sv
// Reloadable down-counter: emits a pulse when an input pulse arrives at count 0.
module apu_pulse_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             pulse_in,
   input  logic             reload_in,
   input  logic [WIDTH-1:0] period_in,
   output logic             pulse_out
);

   logic [WIDTH-1:0] count_q, count_d;

   assign pulse_out = pulse_in && (count_q == '0);

   // Reload on expiry or forced reload, otherwise count down; only on input pulses
   always_comb begin
      count_d = count_q;
      if (pulse_in) begin
         if ((count_q == '0) || reload_in) begin
            count_d = period_in;
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   // Counter state
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/apu_pulse_gen.sv
// Square-wave channel: timer, 8-step sequencer, envelope, sweep and length counter.
module apu_pulse_gen
   import apu_pkg::*;
#(
   parameter int unsigned CHANNEL    = 0,
   parameter int unsigned TIMER_BITS = 11
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       en_in,
   input  logic       cpu_cycle_pulse_in,
   input  logic       lc_pulse_in,
   input  logic       eg_pulse_in,
   input  logic [2:0] a_in,
   input  logic [7:0] d_in,
   input  logic       wr_in,
   output logic [3:0] pulse_out,
   output logic       active_out,
   output logic       sweep_mute_out
);

   localparam int unsigned TW = TIMER_BITS + 1;

   logic wr_ctrl, wr_sweep, wr_tlo, wr_thi, wr_custom, wr_custom_en;

   assign wr_ctrl      = wr_in && (a_in == ADDR_CTRL);
   assign wr_sweep     = wr_in && (a_in == ADDR_SWEEP);
   assign wr_tlo       = wr_in && (a_in == ADDR_TIMER_LO);
   assign wr_thi       = wr_in && (a_in == ADDR_TIMER_HI);
   assign wr_custom    = wr_in && (a_in == ADDR_CUSTOM);
   assign wr_custom_en = wr_in && (a_in == ADDR_CUSTOM_EN);

   ctrl_reg_t             ctrl_q, ctrl_d;
   sweep_reg_t            sweep_q, sweep_d;
   logic [TIMER_BITS-1:0] period_q, period_d;
   logic                  sw_reload_q, sw_reload_d;
   logic [7:0]            len_q, len_d;
   logic [2:0]            step_q, step_d;
   logic                  env_start_q, env_start_d;
   logic [3:0]            decay_q, decay_d;
   logic [7:0]            custom_q, custom_d;
   logic                  custom_en_q, custom_en_d;
   logic [3:0]            pulse_q, pulse_d;

   logic step_tick, sw_tick, env_tick;

   apu_pulse_divider #(.WIDTH(TW)) u_timer (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .pulse_in  (cpu_cycle_pulse_in),
      .reload_in (1'b0),
      .period_in ({period_q, 1'b1}),
      .pulse_out (step_tick)
   );

   apu_pulse_divider #(.WIDTH(3)) u_sweep_div (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .pulse_in  (lc_pulse_in),
      .reload_in (sw_reload_q),
      .period_in (sweep_q.period),
      .pulse_out (sw_tick)
   );

   // The start flag forces the envelope divider to reload with vol
   apu_pulse_divider #(.WIDTH(4)) u_env_div (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .pulse_in  (eg_pulse_in),
      .reload_in (env_start_q),
      .period_in (ctrl_q.vol),
      .pulse_out (env_tick)
   );

   logic [TIMER_BITS:0] p_ext, delta, target;
   logic                mute;

   // Sweep target and mute, one bit wider than the period to catch overflow
   always_comb begin
      p_ext = {1'b0, period_q};
      delta = p_ext >> sweep_q.shift;
      if (!sweep_q.negate) begin
         target = p_ext + delta;
      end else if (CHANNEL == 0) begin
         target = p_ext - delta - TW'(1);
      end else begin
         target = p_ext - delta;
      end
      mute = (period_q < TIMER_BITS'(8)) || (!sweep_q.negate && target[TIMER_BITS]);
   end

   logic [7:0] pattern;
   logic       seq_bit;
   logic [3:0] env_level;

   // Sample selection from the current sequencer step and envelope
   always_comb begin
      pattern   = custom_en_q ? custom_q : DUTY_PAT[ctrl_q.duty];
      seq_bit   = pattern[step_q];
      env_level = ctrl_q.const_vol ? ctrl_q.vol : decay_q;
      pulse_d   = (seq_bit && (len_q != 8'd0) && !mute) ? env_level : 4'd0;
   end

   // Next-state for registers, sequencer, envelope, sweep and length; CPU writes win
   always_comb begin
      ctrl_d      = ctrl_q;
      sweep_d     = sweep_q;
      period_d    = period_q;
      sw_reload_d = sw_reload_q;
      len_d       = len_q;
      step_d      = step_q;
      env_start_d = env_start_q;
      decay_d     = decay_q;
      custom_d    = custom_q;
      custom_en_d = custom_en_q;

      if (wr_thi) begin
         step_d = 3'd0;
      end else if (step_tick) begin
         step_d = step_q - 3'd1;
      end

      if (eg_pulse_in) begin
         if (env_start_q) begin
            env_start_d = 1'b0;
            decay_d     = 4'd15;
         end else if (env_tick) begin
            if (decay_q != 4'd0) begin
               decay_d = decay_q - 4'd1;
            end else if (ctrl_q.halt) begin
               decay_d = 4'd15;
            end
         end
      end
      if (wr_thi) begin
         env_start_d = 1'b1;
      end

      if (lc_pulse_in) begin
         if (sw_tick && sweep_q.en && (sweep_q.shift != 3'd0) && !mute) begin
            period_d = target[TIMER_BITS-1:0];
         end
         sw_reload_d = 1'b0;
      end
      // A sweep write alongside lc_pulse_in leaves reload pending for the next one
      if (wr_sweep) begin
         sweep_d     = sweep_reg_t'(d_in);
         sw_reload_d = 1'b1;
      end

      if (!en_in) begin
         len_d = 8'd0;
      end else if (wr_thi) begin
         len_d = LEN_TABLE[d_in[7:3]];
      end else if (lc_pulse_in && !ctrl_q.halt && (len_q != 8'd0)) begin
         len_d = len_q - 8'd1;
      end

      if (wr_ctrl) begin
         ctrl_d = ctrl_reg_t'(d_in);
      end
      if (wr_tlo) begin
         period_d[7:0] = d_in;
      end
      if (wr_thi) begin
         period_d[TIMER_BITS-1:8] = d_in[TIMER_BITS-9:0];
      end
      if (wr_custom) begin
         custom_d = d_in;
      end
      if (wr_custom_en) begin
         custom_en_d = d_in[0];
      end
   end

   // Channel state and registered sample
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         ctrl_q      <= '0;
         sweep_q     <= '0;
         period_q    <= '0;
         sw_reload_q <= 1'b0;
         len_q       <= '0;
         step_q      <= '0;
         env_start_q <= 1'b0;
         decay_q     <= '0;
         custom_q    <= '0;
         custom_en_q <= 1'b0;
         pulse_q     <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         sweep_q     <= sweep_d;
         period_q    <= period_d;
         sw_reload_q <= sw_reload_d;
         len_q       <= len_d;
         step_q      <= step_d;
         env_start_q <= env_start_d;
         decay_q     <= decay_d;
         custom_q    <= custom_d;
         custom_en_q <= custom_en_d;
         pulse_q     <= pulse_d;
      end
   end

   assign pulse_out      = pulse_q;
   assign active_out     = (len_q != 8'd0);
   assign sweep_mute_out = mute;

endmodule

// File: tb/tb_apu_pulse_gen.sv
// Self-checking bench for apu_pulse_gen: directed scenarios plus random traffic vs a model.
module tb_apu_pulse_gen;

   localparam int CH = 0;
   localparam int TB = 11;

   logic       clk_in = 1'b0;
   logic       rst_n_in, en_in, cpu_cycle_pulse_in, lc_pulse_in, eg_pulse_in, wr_in;
   logic [2:0] a_in;
   logic [7:0] d_in;
   logic [3:0] pulse_out;
   logic       active_out, sweep_mute_out;

   apu_pulse_gen #(.CHANNEL(CH), .TIMER_BITS(TB)) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .en_in              (en_in),
      .cpu_cycle_pulse_in (cpu_cycle_pulse_in),
      .lc_pulse_in        (lc_pulse_in),
      .eg_pulse_in        (eg_pulse_in),
      .a_in               (a_in),
      .d_in               (d_in),
      .wr_in              (wr_in),
      .pulse_out          (pulse_out),
      .active_out         (active_out),
      .sweep_mute_out     (sweep_mute_out)
   );

   always #5 clk_in = ~clk_in;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model state, plain integers
   int m_p, m_duty, m_halt, m_const, m_vol;
   int m_sen, m_sper, m_neg, m_sh, m_reload, m_sdiv;
   int m_len, m_step, m_tmr, m_start, m_decay, m_ediv, m_cust, m_cust_en, m_pulse;

   int len_tab[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                       12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   function automatic int duty_pat(input int i);
      case (i)
         0: return 'h80;
         1: return 'hC0;
         2: return 'hF0;
         default: return 'h3F;
      endcase
   endfunction

   function automatic bit m_mute();
      return (m_p < 8) || (m_neg == 0 && (m_p + (m_p >> m_sh)) >= (1 << TB));
   endfunction

   function automatic int m_target();
      int t;
      if (m_neg != 0) t = m_p - (m_p >> m_sh) - ((CH == 0) ? 1 : 0);
      else            t = m_p + (m_p >> m_sh);
      return t & ((1 << TB) - 1);
   endfunction

   task automatic model_reset();
      m_p = 0; m_duty = 0; m_halt = 0; m_const = 0; m_vol = 0;
      m_sen = 0; m_sper = 0; m_neg = 0; m_sh = 0; m_reload = 0; m_sdiv = 0;
      m_len = 0; m_step = 0; m_tmr = 0; m_start = 0; m_decay = 0; m_ediv = 0;
      m_cust = 0; m_cust_en = 0; m_pulse = 0;
   endtask

   // One clock of the channel: everything uses the pre-edge state, then writes land
   task automatic model_clock(input bit cpu, input bit lc, input bit eg, input bit wr,
                              input int a, input int d);
      int  pat, lvl, nxt_pulse, new_p;
      bit  step_ev;
      pat       = (m_cust_en != 0) ? m_cust : duty_pat(m_duty);
      lvl       = (m_const != 0) ? m_vol : m_decay;
      nxt_pulse = (((pat >> m_step) & 1) != 0 && m_len != 0 && !m_mute()) ? lvl : 0;

      // m_tmr = CPU cycles still to go before the next step
      step_ev = cpu && (m_tmr == 0);
      if (cpu) m_tmr = (m_tmr == 0) ? 2 * m_p + 1 : m_tmr - 1;
      if (wr && a == 3) m_step = 0;
      else if (step_ev) m_step = (m_step + 7) % 8;

      if (eg) begin
         if (m_start != 0) begin
            m_start = 0; m_decay = 15; m_ediv = m_vol;
         end else if (m_ediv == 0) begin
            m_ediv = m_vol;
            if (m_decay > 0) m_decay--;
            else if (m_halt != 0) m_decay = 15;
         end else begin
            m_ediv--;
         end
      end
      if (wr && a == 3) m_start = 1;

      new_p = m_p;
      if (lc) begin
         if (m_sdiv == 0 && m_sen != 0 && m_sh != 0 && !m_mute()) new_p = m_target();
         if (m_sdiv == 0 || m_reload != 0) begin
            m_sdiv = m_sper; m_reload = 0;
         end else begin
            m_sdiv--;
         end
      end

      if (!en_in) m_len = 0;
      else if (wr && a == 3) m_len = len_tab[d >> 3];
      else if (lc && m_halt == 0 && m_len > 0) m_len--;

      if (wr) begin
         case (a)
            0: begin
               m_duty = (d >> 6) & 3; m_halt = (d >> 5) & 1;
               m_const = (d >> 4) & 1; m_vol = d & 15;
            end
            1: begin
               m_sen = (d >> 7) & 1; m_sper = (d >> 4) & 7;
               m_neg = (d >> 3) & 1; m_sh = d & 7; m_reload = 1;
            end
            2: new_p = (new_p & ~255) | d;
            3: new_p = (new_p & 255) | ((d & ((1 << (TB - 8)) - 1)) << 8);
            4: m_cust = d;
            5: m_cust_en = d & 1;
            default: ;
         endcase
      end
      m_p     = new_p;
      m_pulse = nxt_pulse;
   endtask

   task automatic tick(input bit cpu, input bit lc, input bit eg, input bit wr,
                       input int a, input int d);
      cpu_cycle_pulse_in = cpu;
      lc_pulse_in        = lc;
      eg_pulse_in        = eg;
      wr_in              = wr;
      a_in               = 3'(a);
      d_in               = 8'(d);
      model_clock(cpu, lc, eg, wr, a, d);
      @(posedge clk_in);
      #1;
      check("pulse_out", 32'(pulse_out), 32'(m_pulse));
      check("active_out", 32'(active_out), 32'(m_len != 0));
      check("sweep_mute_out", 32'(sweep_mute_out), 32'(m_mute()));
      cpu_cycle_pulse_in = 1'b0;
      lc_pulse_in        = 1'b0;
      eg_pulse_in        = 1'b0;
      wr_in              = 1'b0;
   endtask

   task automatic wr_reg(input int a, input int d);
      tick(1'b0, 1'b0, 1'b0, 1'b1, a, d);
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      en_in    = 1'b0;
      model_reset();
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
   endtask

   initial begin
      int         high;
      int         waited;
      logic [7:0] cp;
      int         a, d, r;
      bit         cpu, lc, eg, wr;

      rst_n_in = 1'b0; en_in = 1'b0; cpu_cycle_pulse_in = 1'b0; lc_pulse_in = 1'b0;
      eg_pulse_in = 1'b0; wr_in = 1'b0; a_in = 3'd0; d_in = 8'd0;
      #2;
      do_reset();
      check("rst_pulse", 32'(pulse_out), 32'd0);
      check("rst_active", 32'(active_out), 32'd0);
      check("rst_mute", 32'(sweep_mute_out), 32'd1);

      // Duty 2, constant volume 9, P = 0x0FD: 4 steps high, 4 low, 508 cycles each
      en_in = 1'b1;
      wr_reg(0, 'h99);
      wr_reg(2, 'hFD);
      wr_reg(3, 'h08);
      high = 0;
      repeat (4064) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
         if (pulse_out == 4'd9) high++;
      end
      check("duty_high_cycles", 32'(high), 32'd2032);

      // Sweep add: 0x100 + 0x80
      do_reset();
      en_in = 1'b1;
      wr_reg(2, 'h00);
      wr_reg(3, 'h01);
      wr_reg(1, 'h81);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("sweep_add_p", 32'(dut.period_q), 32'h180);

      // Sweep negate
      do_reset();
      en_in = 1'b1;
      wr_reg(2, 'h00);
      wr_reg(3, 'h01);
      wr_reg(1, 'h89);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("sweep_neg_p", 32'(dut.period_q), (CH == 0) ? 32'h07F : 32'h080);

      // Sweep overflow mute at P = 0x7FF
      do_reset();
      en_in = 1'b1;
      wr_reg(0, 'hD9);
      wr_reg(2, 'hFF);
      wr_reg(3, 'h0F);
      wr_reg(1, 'h81);
      repeat (20) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      check("mute_p_kept", 32'(dut.period_q), 32'h7FF);
      check("mute_flag", 32'(sweep_mute_out), 32'd1);
      check("mute_pulse", 32'(pulse_out), 32'd0);

      // Length index 0 (10) counts down, then enable clear and blocked load
      do_reset();
      en_in = 1'b1;
      wr_reg(0, 'h10);
      wr_reg(3, 'h00);
      repeat (9) tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("len_after_9", 32'(active_out), 32'd1);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("len_after_10", 32'(active_out), 32'd0);
      wr_reg(3, 'h08);
      check("len_reload", 32'(active_out), 32'd1);
      en_in = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("en_clear", 32'(active_out), 32'd0);
      wr_reg(3, 'h08);
      check("load_while_off", 32'(active_out), 32'd0);

      // Custom pattern 0xA5, P = 0x10 so one step per 34 CPU cycles
      do_reset();
      en_in = 1'b1;
      wr_reg(0, 'h1F);
      wr_reg(2, 'h10);
      wr_reg(3, 'h08);
      wr_reg(4, 'hA5);
      wr_reg(5, 'h01);
      cp = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         repeat (34) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
         check($sformatf("custom_step%0d", 7 - k), 32'(pulse_out), cp[7-k] ? 32'd15 : 32'd0);
      end

      // Asynchronous reset while the tone is high
      waited = 0;
      while (pulse_out == 4'd0 && waited < 100) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
         waited++;
      end
      check("tone_high_before_rst", 32'(pulse_out != 4'd0), 32'd1);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_pulse", 32'(pulse_out), 32'd0);
      model_reset();
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;

      // Random traffic with coincident writes and frame pulses
      en_in = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         r   = int'($urandom_range(0, 99));
         cpu = ($urandom_range(0, 3) != 0);
         lc  = ($urandom_range(0, 49) == 0);
         eg  = ($urandom_range(0, 29) == 0);
         wr  = 1'b0;
         a   = 0;
         d   = 0;
         if (r < 4) begin
            wr = 1'b1;
            a  = int'($urandom_range(0, 5));
            d  = int'($urandom_range(0, 255));
            if (a == 3 && $urandom_range(0, 7) != 0) d = d & 'hF8;
         end else if (r == 4) begin
            en_in = ($urandom_range(0, 4) != 0);
         end
         tick(cpu, lc, eg, wr, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
